// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the Viterbi sequencing controller.
package viterbi_pkg;

  localparam int unsigned DEF_FRAME_LEN = 12;
  localparam int unsigned DEF_TB_DEPTH  = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BRCH = 3'd1,
    ST_ACS  = 3'd2,
    ST_RUN  = 3'd3,
    ST_TBCK = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  typedef struct packed {
    logic brch;
    logic add;
    logic mem;
    logic tbck;
  } stage_en_t;

  function automatic stage_en_t stage_en(state_e s);
    stage_en_t e;
    e = '0;
    case (s)
      ST_BRCH: e.brch = 1'b1;
      ST_ACS:  begin e.brch = 1'b1; e.add = 1'b1; end
      ST_RUN:  begin e.brch = 1'b1; e.add = 1'b1; e.mem = 1'b1; end
      ST_TBCK: begin e.mem = 1'b1; e.tbck = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/viterbi_ctrl_p_if.sv
// Control/status bundle between the datapath sequencer and its driver.
interface viterbi_ctrl_p_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             start;
  logic             abort;
  logic             en_brch;
  logic             en_add;
  logic             en_mem;
  logic             en_tbck;
  logic [CNT_W-1:0] tb_step;
  logic             busy;
  logic             done;

  modport master (
    output en, start, abort,
    input  en_brch, en_add, en_mem, en_tbck, tb_step, busy, done
  );

  modport slave (
    input  en, start, abort,
    output en_brch, en_add, en_mem, en_tbck, tb_step, busy, done
  );
endinterface

// File: rtl/viterbi_cnt.sv
// Up-counter with advance qualifier, synchronous clear and terminal-count flag.
module viterbi_cnt #(
  parameter int unsigned W    = 8,
  parameter int unsigned LAST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        cnt_q <= '0;
      end else if (inc_i) begin
        cnt_q <= cnt_q + W'(1);
      end
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == W'(LAST));

endmodule

// File: rtl/viterbi_ctrl_p.sv
// Viterbi datapath sequencer: BRCH -> ACS -> RUN (frame) -> TBCK (traceback) -> DONE.
module viterbi_ctrl_p
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned TB_DEPTH  = DEF_TB_DEPTH,
  parameter int unsigned CNT_W     = 8,
  parameter bit          CONT_MODE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  viterbi_ctrl_p_if.slave        bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sym_cnt, tb_cnt, tb_step_d, tb_step_q;
  logic             sym_tc, tb_tc;
  logic             sym_clr, sym_inc, tb_clr, tb_inc;
  stage_en_t        stg_q;
  logic             busy_q, done_q;
  logic             unused_sym_cnt;

  // Counters stop at their terminal value so they cannot wrap.
  assign sym_clr = bus.abort || (state_q == ST_ACS);
  assign sym_inc = (state_q == ST_RUN) && !sym_tc;
  assign tb_clr  = bus.abort || (state_q == ST_RUN);
  assign tb_inc  = (state_q == ST_TBCK) && !tb_tc;

  viterbi_cnt #(
    .W    (CNT_W),
    .LAST (FRAME_LEN - 1)
  ) u_sym_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (bus.en),
    .clr_i (sym_clr),
    .inc_i (sym_inc),
    .cnt_o (sym_cnt),
    .tc_o  (sym_tc)
  );

  viterbi_cnt #(
    .W    (CNT_W),
    .LAST (TB_DEPTH - 1)
  ) u_tb_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (bus.en),
    .clr_i (tb_clr),
    .inc_i (tb_inc),
    .cnt_o (tb_cnt),
    .tc_o  (tb_tc)
  );

  assign unused_sym_cnt = ^sym_cnt;

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = bus.start ? ST_BRCH : ST_IDLE;
        ST_BRCH: state_d = ST_ACS;
        ST_ACS:  state_d = ST_RUN;
        ST_RUN:  state_d = sym_tc ? ST_TBCK : ST_RUN;
        ST_TBCK: state_d = tb_tc ? ST_DONE : ST_TBCK;
        ST_DONE: state_d = (CONT_MODE && bus.start) ? ST_BRCH : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_comb begin
    tb_step_d = '0;
    if ((state_d == ST_TBCK) && (state_q == ST_TBCK)) begin
      tb_step_d = tb_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tb_step_q <= '0;
    end else if (bus.en) begin
      state_q   <= state_d;
      stg_q     <= stage_en(state_d);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      tb_step_q <= tb_step_d;
    end
  end

  assign bus.en_brch = stg_q.brch;
  assign bus.en_add  = stg_q.add;
  assign bus.en_mem  = stg_q.mem;
  assign bus.en_tbck = stg_q.tbck;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.tb_step = tb_step_q;

endmodule
